// File: rtl/dcc16.sv
// dcc16: loadable down counter/timer with run control and a one-cycle tc pulse.
// Define DCC16_AUTORELOAD_EN for periodic reload at terminal count.
module dcc16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dec_d;
  logic             busy_q;
  logic             tc_q;
  logic             go_d;
`ifdef DCC16_AUTORELOAD_EN
  logic [WIDTH-1:0] rld_q;
`endif

  assign dec_d = q_q - ONE;
  // start from IDLE only launches when the count it would run is nonzero
  assign go_d  = (state_q == IDLE) && start && !stop
               && ((load ? load_val : q_q) != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef DCC16_AUTORELOAD_EN
      rld_q   <= '0;
`endif
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        q_q <= load_val;
`ifdef DCC16_AUTORELOAD_EN
        rld_q <= load_val;
`endif
        if (go_d) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end else if (stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (state_q == IDLE) begin
        if (go_d) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end else if (en) begin
        if (q_q > ONE) begin
          q_q <= dec_d;
        end else if (q_q == ONE) begin
          tc_q <= 1'b1;
`ifdef DCC16_AUTORELOAD_EN
          q_q  <= rld_q;
`else
          q_q     <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
      end
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_dcc16.sv
// tb_dcc16: scoreboard bench for dcc16.
// Expected q/busy/tc are queued per driven cycle and popped after the edge.
module tb_dcc16;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        en;
  logic [15:0] q;
  logic        busy;
  logic        tc;

  typedef struct {
    logic [15:0] q;
    logic        busy;
    logic        tc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  dcc16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .stop    (stop),
    .en      (en),
    .q       (q),
    .busy    (busy),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic l, input logic [15:0] lv,
                     input logic s, input logic sp, input logic e,
                     input logic [15:0] eq, input logic eb,
                     input logic et, input string tag);
    exp_t x;
    load     = l;
    load_val = lv;
    start    = s;
    stop     = sp;
    en       = e;
    sb.push_back('{eq, eb, et, tag});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".q"},    32'(q),    32'(x.q));
    chk({x.tag, ".busy"}, 32'(busy), 32'(x.busy));
    chk({x.tag, ".tc"},   32'(tc),   32'(x.tc));
  endtask

  initial begin
    reset = 1'b0;
    load = 0; load_val = '0; start = 0; stop = 0; en = 0;
    #12;
    chk("rst.q",    32'(q),    32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.tc",   32'(tc),   32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // one-shot count of 5
    cyc(1, 16'd5, 1, 0, 1, 16'd5, 1, 0, "os.ld");
    cyc(0, 0, 0, 0, 1, 16'd4, 1, 0, "os.4");
    cyc(0, 0, 0, 0, 1, 16'd3, 1, 0, "os.3");
    cyc(0, 0, 0, 0, 1, 16'd2, 1, 0, "os.2");
    cyc(0, 0, 0, 0, 1, 16'd1, 1, 0, "os.1");
`ifdef DCC16_AUTORELOAD_EN
    cyc(0, 0, 0, 0, 1, 16'd5, 1, 1, "os.tc");
    cyc(0, 0, 0, 1, 0, 16'd5, 0, 0, "os.stp");
`else
    cyc(0, 0, 0, 0, 1, 16'd0, 0, 1, "os.tc");
    cyc(0, 0, 0, 0, 1, 16'd0, 0, 0, "os.post");
`endif

    // enable gating and stop
    cyc(1, 16'd3, 1, 0, 0, 16'd3, 1, 0, "eg.ld");
    cyc(0, 0, 0, 0, 1, 16'd2, 1, 0, "eg.e1");
    cyc(0, 0, 0, 0, 0, 16'd2, 1, 0, "eg.e0");
    cyc(0, 0, 0, 0, 1, 16'd1, 1, 0, "eg.e1b");
    cyc(0, 0, 0, 1, 1, 16'd1, 0, 0, "eg.stop");
    cyc(0, 0, 0, 0, 1, 16'd1, 0, 0, "eg.idle1");
    cyc(0, 0, 0, 0, 1, 16'd1, 0, 0, "eg.idle2");

    // priority: load beats terminal count in RUN
    cyc(0, 0, 1, 0, 0, 16'd1, 1, 0, "pr.start");
    cyc(0, 0, 1, 0, 0, 16'd1, 1, 0, "pr.strun");
    cyc(1, 16'd7, 0, 0, 1, 16'd7, 1, 0, "pr.ld");
    cyc(0, 0, 0, 0, 1, 16'd6, 1, 0, "pr.dec");
    cyc(0, 0, 0, 1, 0, 16'd6, 0, 0, "pr.stop");
    cyc(1, 16'd0, 1, 0, 1, 16'd0, 0, 0, "pr.ld0");
    cyc(0, 0, 1, 0, 1, 16'd0, 0, 0, "pr.st0");

    // periodic / one-shot with N=4 over 12 enabled cycles
    cyc(1, 16'd4, 1, 0, 1, 16'd4, 1, 0, "ar.ld");
    for (int k = 1; k <= 12; k++) begin
`ifdef DCC16_AUTORELOAD_EN
      cyc(0, 0, 0, 0, 1, 16'(4 - (k % 4)), 1, (k % 4) == 0, "ar.run");
`else
      cyc(0, 0, 0, 0, 1, (k < 4) ? 16'(4 - k) : 16'd0, k < 4, k == 4,
          "ar.run");
`endif
    end
    cyc(0, 0, 0, 1, 0, q, 0, 0, "ar.stop");

    // full-range count from 0xFFFF
    cyc(1, 16'hFFFF, 1, 0, 1, 16'hFFFF, 1, 0, "bd.ld");
    for (int k = 1; k < 65535; k++)
      cyc(0, 0, 0, 0, 1, 16'(65535 - k), 1, 0, "bd.run");
`ifdef DCC16_AUTORELOAD_EN
    cyc(0, 0, 0, 0, 1, 16'hFFFF, 1, 1, "bd.tc");
    cyc(0, 0, 0, 0, 1, 16'hFFFE, 1, 0, "bd.wrap");
    cyc(0, 0, 0, 1, 0, 16'hFFFE, 0, 0, "bd.stop");
`else
    cyc(0, 0, 0, 0, 1, 16'h0000, 0, 1, "bd.tc");
    cyc(0, 0, 0, 0, 1, 16'h0000, 0, 0, "bd.nouf");
    cyc(0, 0, 1, 0, 1, 16'h0000, 0, 0, "bd.st0");
`endif

    // asynchronous reset mid-count
    cyc(1, 16'h1234, 1, 0, 0, 16'h1234, 1, 0, "ar2.ld");
    cyc(0, 0, 0, 0, 0, 16'h1234, 1, 0, "ar2.hold");
    #2;
    reset = 1'b0;
    #1;
    chk("arst.q",    32'(q),    32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.tc",   32'(tc),   32'h0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 1, 16'h0000, 0, 0, "arst.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcc16.md
# dcc16

Synchronous, loadable 16-bit down counter/timer with a small run-control state machine and a one-cycle terminal-count pulse. It is the counting-down complement to the free-running ripple up-counters in the counter library. It times a programmed number of enabled clock cycles and flags expiry to control logic. All flops share one clock edge, so its outputs are glitch-free, unlike ripple stages.

## Interface
- `WIDTH`, 16, counter width in bits; all widths below scale with it.
- `clk` input 1: rising-edge clock; the only clock.
- `reset` input 1: asynchronous, active-low reset; clears all state immediately while low.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: value loaded into `q` (and the reload register) when `load`=1.
- `start` input 1: request to begin counting.
- `stop` input 1: abort counting; `q` holds its value.
- `en` input 1: count enable; a decrement happens only in RUN with `en`=1.
- `q` output WIDTH: current count, registered.
- `busy` output 1: high while in RUN, registered.
- `tc` output 1: terminal-count pulse, registered, one cycle wide.

## Operation
- States: IDLE, RUN. Reset state is IDLE.
- Reset values: `q`=0, `busy`=0, `tc`=0, reload register=0.
- Priority per edge: `load` > `stop` > `start` > count.
- `load`=1 in any state: `q`<=`load_val` and reload register<=`load_val`. No decrement and no `tc` that cycle.
- IDLE:
  - `start`=1 and next-`q`≠0 (next-`q` includes a same-cycle load) -> RUN.
  - `start`=1 and next-`q`=0 -> stays IDLE, no `tc`.
  - `en` is ignored in IDLE.
- RUN:
  - `stop`=1 (and no `load`) -> IDLE, `q` holds.
  - `start` is ignored.
  - `load` in RUN reloads and stays in RUN.
  - `en`=1 and `q`>1 -> `q`<=`q`-1.
  - `en`=1 and `q`=1 -> terminal event (see Configuration).
  - `en`=0 -> `q` holds.
- No underflow: `q` never wraps from 0 to all-ones under any input combination.
- `busy` = (state==RUN).

## Timing
- Load latency: 1 cycle; `q` shows `load_val` after the load edge.
- With `load_val`=N≥1 loaded and started on edge E0, and `en` held high:
  - `q` = N-k after edge E0+k.
  - The terminal event occurs on edge E0+N.
  - `tc`=1 during the cycle following edge E0+N only.
- `tc` is high for exactly one cycle per terminal event. It is never asserted by load, start, stop or reset.
- `stop` and `load` take effect on the same edge; no pipelined residue.
- Reset asserted mid-count: `q`, `busy` and `tc` go to 0 asynchronously. After release, the first edge behaves as from IDLE.

## Configuration
- Macro `DCC16_AUTORELOAD_EN`.
- Defined: at the terminal event, `q`<=reload register, `tc` pulses, and the state stays RUN, giving a periodic pulse every N enabled cycles. If the reload register is 1, `tc` is high every enabled cycle.
- Undefined: at the terminal event, `q`<=0, `tc` pulses, and the state goes to IDLE (`busy` falls on the same edge). The reload register is then unused and may be optimized away.

## Test plan
- Reset: drive `reset`=0 mid-count with `q`=0x1234 -> `q`=0, `busy`=0, `tc`=0 immediately, without waiting for a clock edge.
- One-shot (macro undefined): load 5 with start, `en`=1 -> `q` goes 4,3,2,1,0; `tc`=1 for one cycle exactly when `q`=0; `busy` falls on that same edge.
- Enable gating and stop: load 3, start, `en` toggled 1,0,1 -> `q` goes 2,2,1. Then assert `stop` -> IDLE with `q`=1; further `en` pulses leave `q`=1.
- Priority: in RUN with `q`=1, assert `load`=7 and `en`=1 together -> `q`=7, no `tc`, still RUN. Separately, `start` with `load_val`=0 -> stays IDLE, no `tc`.
- Autoreload (macro defined): load 4, start, `en`=1 for 12 cycles -> `tc` pulses on cycles 4, 8 and 12; `q` cycles 3,2,1,4; `busy` stays 1.
- Boundary: load 0xFFFF and count to terminal -> exactly 65535 enabled cycles to `tc`. `q` never passes from 0 to 0xFFFF by decrement.
